multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Main control FSM for the multicycle MIPS32 datapath; the initiator side of the ALU control interface. Decodes opcode/funct, sequences fetch/decode/execute/memory/writeback, drives the 4-bit ALU operation code and all datapath muxes/enables. Consumes the ALU Zero flag for branches and a memory-ready handshake for variable-latency memory.

Parameters:
RESET_PC_SRC, 2'b00, pc_source value driven while in reset/FETCH (fixed PC+4 path)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
opcode  in  6  instruction[31:26], valid from DECODE onward (IR latched)
funct  in  6  instruction[5:0]
zero  in  1  ALU Zero flag, same-cycle combinational
mem_ready  in  1  memory completes access this cycle
alu_ctl  out  4  AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12
alu_src_a  out  1  0=PC, 1=reg A
alu_src_b  out  2  0=reg B, 1=const 4, 2=sext imm, 3=sext imm<<2
pc_source  out  2  0=ALU result, 1=ALUOut reg, 2=jump target
pc_write  out  1  PC load enable (branch-qualified internally)
iord  out  1  0=PC address, 1=ALUOut address
mem_read / mem_write  out  1 each  memory strobes
ir_write  out  1  instruction register load
reg_write  out  1  register file write
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
instr_done  out  1  one-cycle pulse on instruction retire
illegal_op  out  1  one-cycle pulse on unsupported opcode/funct
state  out  4  current state, debug

Behaviour:
- States (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, JUMP=9, ADDI_EX=10, ADDI_WB=11.
- Async reset: state<=FETCH immediately; all outputs forced 0 while reset high. After release, Moore decode of state; pc_write is Mealy on zero in BEQ and on mem_ready in FETCH.
- Unlisted outputs are 0 in every state.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_ctl=2, pc_source=0. Hold while mem_ready=0. When mem_ready=1, ir_write=1, pc_write=1, go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_ctl=2 (branch target into ALUOut). Next by opcode: 0x23/0x2B->MEMADR, 0x00->EXEC, 0x04->BEQ, 0x02->JUMP, 0x08->ADDI_EX. Any other opcode -> illegal_op=1, next FETCH.
- R-type funct check happens in DECODE. Legal funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt. Any other funct -> illegal_op=1, next FETCH.
- MEMADR: alu_src_a=1, alu_src_b=2, alu_ctl=2. Next: MEMRD if opcode=0x23, else MEMWR.
- MEMRD: mem_read=1, iord=1; hold until mem_ready; then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1; then FETCH.
- MEMWR: mem_write=1, iord=1; hold until mem_ready; that cycle instr_done=1, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=0, alu_ctl from funct map; next RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; next FETCH.
- BEQ: alu_src_a=1, alu_src_b=0, alu_ctl=6, pc_source=1, pc_write=zero, instr_done=1; next FETCH.
- JUMP: pc_source=2, pc_write=1, instr_done=1; next FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=2, alu_ctl=2; next ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1; next FETCH.
- Encodings 12–15 are unreachable; if entered, go to FETCH with all outputs 0.
- Latencies with mem_ready tied high (cycles, FETCH inclusive): lw 5, sw 4, R/addi 4, beq/j 3.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

Decomposition:
- Package mips_ctl_pkg: opcode constants, funct constants, ALU op constants (0, 1, 2, 6, 7, 12), state enum, alu_src_b encodings.
- One sub-module alu_decoder: combinational funct->alu_ctl map plus funct_legal flag. Shared with a future single-cycle control.

Test Plan:
1. Assert reset while in MEMRD with mem_ready=0 -> state=0 and all outputs 0 same cycle. Release -> FETCH with mem_read=1, alu_ctl=2, alu_src_b=1.
2. opcode=0x00, funct=0x20, mem_ready=1 -> states 0,1,6,7,0. EXEC alu_ctl=2 with alu_src_a=1, alu_src_b=0. RWB reg_write=1, reg_dst=1, instr_done pulse. Repeat with funct 0x2A -> 7 and 0x27 -> 12.
3. opcode=0x23, mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles with mem_read=1, iord=1. Then MEMWB with reg_write=1, mem_to_reg=1.
4. opcode=0x04: zero=1 -> pc_write=1, pc_source=1, alu_ctl=6. zero=0 -> pc_write=0. Both return to FETCH.
5. opcode=0x3F -> illegal_op pulses once in DECODE, next state FETCH, no reg_write. opcode=0x00 with funct=0x00 -> same.
6. opcode=0x02 -> JUMP with pc_source=2, pc_write=1. opcode=0x2B with mem_ready delayed 2 cycles -> mem_write held 3 cycles, instr_done on the ready cycle.

Source files
------------

// File: rtl/mips_ctl_pkg.sv
// Shared encodings for the multicycle MIPS32 control path: opcodes, funct codes,
// ALU operation codes, FSM state encoding and datapath mux selects.
package mips_ctl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BEQ     = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11
    } state_t;

    // Complete control word; the top drives every output port from one of these.
    typedef struct packed {
        logic [3:0] alu_ctl;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       instr_done;
        logic       illegal_op;
    } ctl_t;

    function automatic logic opcode_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ALU operation map with a legality flag; purely combinational
// so it can be reused by a single-cycle control unit.
module alu_decoder
    import mips_ctl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ctl,
    output logic       funct_legal
);

    always_comb begin
        alu_ctl     = ALU_ADD;
        funct_legal = 1'b1;
        case (funct)
            FN_ADD:  alu_ctl = ALU_ADD;
            FN_SUB:  alu_ctl = ALU_SUB;
            FN_AND:  alu_ctl = ALU_AND;
            FN_OR:   alu_ctl = ALU_OR;
            FN_NOR:  alu_ctl = ALU_NOR;
            FN_SLT:  alu_ctl = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS32 datapath: sequences fetch through
// writeback, drives ALU op codes and all datapath selects/enables.
module multicycle_control
    import mips_ctl_pkg::*;
#(
    parameter logic [1:0] RESET_PC_SRC = PCSRC_ALU
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] alu_ctl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] w_funct_alu_ctl;
    logic       w_funct_legal;
    logic       w_illegal;
    ctl_t       w_ctl;
    ctl_t       w_ctl_out;

    alu_decoder u_alu_decoder (
        .funct       (funct),
        .alu_ctl     (w_funct_alu_ctl),
        .funct_legal (w_funct_legal)
    );

    assign w_illegal = !opcode_supported(opcode) ||
                       ((opcode == OP_RTYPE) && !w_funct_legal);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:   w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = w_funct_legal ? S_EXEC : S_FETCH;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_J:         w_next_state = S_JUMP;
                    OP_ADDI:      w_next_state = S_ADDI_EX;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next_state = S_FETCH;
            S_MEMWR:   w_next_state = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:    w_next_state = S_RWB;
            S_RWB:     w_next_state = S_FETCH;
            S_BEQ:     w_next_state = S_FETCH;
            S_JUMP:    w_next_state = S_FETCH;
            S_ADDI_EX: w_next_state = S_ADDI_WB;
            S_ADDI_WB: w_next_state = S_FETCH;
            default:   w_next_state = S_FETCH;
        endcase
    end

    // Moore decode of state; pc_write/ir_write/instr_done follow mem_ready or zero
    // in the cycle the handshake or branch condition resolves.
    always_comb begin
        w_ctl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctl.mem_read  = 1'b1;
                w_ctl.alu_src_b = SRCB_FOUR;
                w_ctl.alu_ctl   = ALU_ADD;
                w_ctl.pc_source = RESET_PC_SRC;
                w_ctl.ir_write  = mem_ready;
                w_ctl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                w_ctl.alu_src_b  = SRCB_IMM_SH2;
                w_ctl.alu_ctl    = ALU_ADD;
                w_ctl.illegal_op = w_illegal;
            end
            S_MEMADR: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = SRCB_IMM;
                w_ctl.alu_ctl   = ALU_ADD;
            end
            S_MEMRD: begin
                w_ctl.mem_read = 1'b1;
                w_ctl.iord     = 1'b1;
            end
            S_MEMWB: begin
                w_ctl.reg_write  = 1'b1;
                w_ctl.mem_to_reg = 1'b1;
                w_ctl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                w_ctl.mem_write  = 1'b1;
                w_ctl.iord       = 1'b1;
                w_ctl.instr_done = mem_ready;
            end
            S_EXEC: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = SRCB_REG;
                w_ctl.alu_ctl   = w_funct_alu_ctl;
            end
            S_RWB: begin
                w_ctl.reg_write  = 1'b1;
                w_ctl.reg_dst    = 1'b1;
                w_ctl.instr_done = 1'b1;
            end
            S_BEQ: begin
                w_ctl.alu_src_a  = 1'b1;
                w_ctl.alu_src_b  = SRCB_REG;
                w_ctl.alu_ctl    = ALU_SUB;
                w_ctl.pc_source  = PCSRC_ALUOUT;
                w_ctl.pc_write   = zero;
                w_ctl.instr_done = 1'b1;
            end
            S_JUMP: begin
                w_ctl.pc_source  = PCSRC_JUMP;
                w_ctl.pc_write   = 1'b1;
                w_ctl.instr_done = 1'b1;
            end
            S_ADDI_EX: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = SRCB_IMM;
                w_ctl.alu_ctl   = ALU_ADD;
            end
            S_ADDI_WB: begin
                w_ctl.reg_write  = 1'b1;
                w_ctl.instr_done = 1'b1;
            end
            default: w_ctl = '0;
        endcase
    end

    // Outputs are squashed combinationally so they go quiet the instant reset rises.
    always_comb begin
        if (reset) begin
            w_ctl_out           = '0;
            w_ctl_out.pc_source = RESET_PC_SRC;
        end else begin
            w_ctl_out = w_ctl;
        end
    end

    assign alu_ctl    = w_ctl_out.alu_ctl;
    assign alu_src_a  = w_ctl_out.alu_src_a;
    assign alu_src_b  = w_ctl_out.alu_src_b;
    assign pc_source  = w_ctl_out.pc_source;
    assign pc_write   = w_ctl_out.pc_write;
    assign iord       = w_ctl_out.iord;
    assign mem_read   = w_ctl_out.mem_read;
    assign mem_write  = w_ctl_out.mem_write;
    assign ir_write   = w_ctl_out.ir_write;
    assign reg_write  = w_ctl_out.reg_write;
    assign reg_dst    = w_ctl_out.reg_dst;
    assign mem_to_reg = w_ctl_out.mem_to_reg;
    assign instr_done = w_ctl_out.instr_done;
    assign illegal_op = w_ctl_out.illegal_op;
    assign state      = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into its expected
// per-cycle trace from the instruction-class rules, then played and compared.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [3:0] alu_ctl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alu_ctl    (alu_ctl),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_source  (pc_source),
        .pc_write   (pc_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .state      (state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] alu;
        logic       a;
        logic [1:0] b;
        logic [1:0] pcs;
        logic       pcw;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       rw;
        logic       rdst;
        logic       m2r;
        logic       done;
        logic       ill;
    } cyc_t;

    cyc_t q_exp[$];
    bit   q_mr[$];
    bit   q_z[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic cyc_t blank(input logic [3:0] st);
        cyc_t c;
        c    = '0;
        c.st = st;
        return c;
    endfunction

    function automatic cyc_t sample();
        cyc_t o;
        o.st = state;     o.alu = alu_ctl;    o.a = alu_src_a;   o.b = alu_src_b;
        o.pcs = pc_source; o.pcw = pc_write;  o.iord = iord;     o.mrd = mem_read;
        o.mwr = mem_write; o.irw = ir_write;  o.rw = reg_write;  o.rdst = reg_dst;
        o.m2r = mem_to_reg; o.done = instr_done; o.ill = illegal_op;
        return o;
    endfunction

    // {legal, alu op} from the R-type funct table.
    function automatic logic [4:0] alu_ref(input logic [5:0] fn);
        case (fn)
            6'h20:   return {1'b1, 4'd2};
            6'h22:   return {1'b1, 4'd6};
            6'h24:   return {1'b1, 4'd0};
            6'h25:   return {1'b1, 4'd1};
            6'h27:   return {1'b1, 4'd12};
            6'h2A:   return {1'b1, 4'd7};
            default: return {1'b0, 4'd0};
        endcase
    endfunction

    task automatic chk(input string tag, input cyc_t exp);
        cyc_t obs;
        obs = sample();
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic add(input cyc_t c, input bit mr, input bit z);
        q_exp.push_back(c);
        q_mr.push_back(mr);
        q_z.push_back(z);
    endtask

    task automatic add_wait(input cyc_t c, input int waits);
        for (int i = 0; i <= waits; i++) add(c, i == waits, 1'($urandom_range(0, 1)));
    endtask

    task automatic build(input logic [5:0] op, input logic [5:0] fn, input bit z,
                         input int fwait, input int mwait);
        cyc_t c;
        logic [4:0] ar;
        bit legal;
        ar = alu_ref(fn);
        for (int i = 0; i <= fwait; i++) begin
            c = blank(4'd0); c.mrd = 1; c.b = 2'd1; c.alu = 4'd2;
            if (i == fwait) begin c.irw = 1; c.pcw = 1; end
            add(c, i == fwait, 1'($urandom_range(0, 1)));
        end
        legal = (op inside {6'h02, 6'h04, 6'h08, 6'h23, 6'h2B}) || (op == 6'h00 && ar[4]);
        c = blank(4'd1); c.b = 2'd3; c.alu = 4'd2; c.ill = !legal;
        add(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if (legal) begin
            case (op)
                6'h00: begin
                    c = blank(4'd6); c.a = 1; c.alu = ar[3:0];
                    add(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    c = blank(4'd7); c.rw = 1; c.rdst = 1; c.done = 1;
                    add(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                6'h23, 6'h2B: begin
                    c = blank(4'd2); c.a = 1; c.b = 2'd2; c.alu = 4'd2;
                    add(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    if (op == 6'h23) begin
                        c = blank(4'd3); c.mrd = 1; c.iord = 1;
                        add_wait(c, mwait);
                        c = blank(4'd4); c.rw = 1; c.m2r = 1; c.done = 1;
                        add(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    end else begin
                        c = blank(4'd5); c.mwr = 1; c.iord = 1;
                        for (int i = 0; i <= mwait; i++) begin
                            c.done = (i == mwait);
                            add(c, i == mwait, 1'($urandom_range(0, 1)));
                        end
                    end
                end
                6'h04: begin
                    c = blank(4'd8); c.a = 1; c.alu = 4'd6; c.pcs = 2'd1; c.pcw = z; c.done = 1;
                    add(c, 1'($urandom_range(0, 1)), z);
                end
                6'h02: begin
                    c = blank(4'd9); c.pcs = 2'd2; c.pcw = 1; c.done = 1;
                    add(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                default: begin
                    c = blank(4'd10); c.a = 1; c.b = 2'd2; c.alu = 4'd2;
                    add(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    c = blank(4'd11); c.rw = 1; c.done = 1;
                    add(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
            endcase
        end
    endtask

    task automatic play(input logic [5:0] op, input logic [5:0] fn, input string name);
        int idx = 0;
        while (q_exp.size() > 0) begin
            @(negedge clk);
            if (idx == 0) begin opcode = op; funct = fn; end
            mem_ready = q_mr.pop_front();
            zero      = q_z.pop_front();
            #1;
            chk($sformatf("%s op=%h fn=%h cyc%0d", name, op, fn, idx), q_exp.pop_front());
            idx++;
        end
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input bit z,
                       input int fwait, input int mwait, input string name);
        build(op, fn, z, fwait, mwait);
        play(op, fn, name);
    endtask

    initial begin
        cyc_t c;
        logic [5:0] legal_fn [6];
        logic [5:0] op;
        logic [5:0] fn;
        legal_fn[0] = 6'h20; legal_fn[1] = 6'h22; legal_fn[2] = 6'h24;
        legal_fn[3] = 6'h25; legal_fn[4] = 6'h27; legal_fn[5] = 6'h2A;

        reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("reset_idle", blank(4'd0));
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        c = blank(4'd0); c.mrd = 1; c.b = 2'd1; c.alu = 4'd2;
        chk("fetch_after_reset", c);

        run(6'h00, 6'h20, 0, 0, 0, "r_add");
        run(6'h00, 6'h2A, 0, 0, 0, "r_slt");
        run(6'h00, 6'h27, 0, 0, 0, "r_nor");
        run(6'h23, 6'h00, 0, 0, 3, "lw_wait3");
        run(6'h04, 6'h00, 1, 0, 0, "beq_taken");
        run(6'h04, 6'h00, 0, 0, 0, "beq_not_taken");
        run(6'h3F, 6'h20, 0, 0, 0, "illegal_opcode");
        run(6'h00, 6'h00, 0, 0, 0, "illegal_funct");
        run(6'h02, 6'h00, 0, 0, 0, "jump");
        run(6'h2B, 6'h00, 0, 0, 2, "sw_wait2");
        run(6'h08, 6'h00, 0, 1, 0, "addi");

        // Asynchronous reset while stalled in MEMRD.
        @(negedge clk);
        opcode = 6'h23; funct = 6'h00; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        c = blank(4'd3); c.mrd = 1; c.iord = 1;
        chk("memrd_stalled", c);
        reset = 1'b1;
        #1 chk("reset_in_memrd", blank(4'd0));
        @(negedge clk);
        #1 chk("reset_held", blank(4'd0));
        reset = 1'b0;
        #1;
        c = blank(4'd0); c.mrd = 1; c.b = 2'd1; c.alu = 4'd2;
        chk("fetch_after_memrd_reset", c);

        for (int n = 0; n < 150; n++) begin
            fn = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 7))
                0: begin op = 6'h00; fn = legal_fn[$urandom_range(0, 5)]; end
                1: op = 6'h00;
                2: op = 6'h23;
                3: op = 6'h2B;
                4: op = 6'h04;
                5: op = 6'h02;
                6: op = 6'h08;
                default: op = 6'($urandom_range(0, 63));
            endcase
            run(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3),
                $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
